// File: rtl/hyperpipe_credit_channel.sv
// Valid/ready stream carried over a retimable register line into an end-of-line FIFO,
// with credit-based, pipelined ready return. Optional statistics: HYPERPIPE_CHANNEL_STATS_EN.
module hyperpipe_credit_channel #(
  parameter int WIDTH        = 32,
  parameter int CYCLES       = 4,
  parameter int READY_CYCLES = 2,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inValid,
  input  logic [WIDTH-1:0]              inData,
  output logic                          inReady,
  output logic                          outValid,
  output logic [WIDTH-1:0]              outData,
  input  logic                          outReady,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic                          overflowErr
`ifdef HYPERPIPE_CHANNEL_STATS_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0]   maxOccupancy,
  output logic [31:0]                   stallCycles,
  output logic [31:0]                   starveCycles
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int PW = $clog2(CYCLES + 2);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hyperpipe_credit_channel: FIFO_DEPTH must be a power of two");
  end
  if (FIFO_DEPTH < READY_CYCLES + 3) begin : g_bad_credit
    $error("hyperpipe_credit_channel: FIFO_DEPTH must be >= READY_CYCLES+3");
  end
  if (CYCLES < 0 || READY_CYCLES < 0) begin : g_bad_stages
    $error("hyperpipe_credit_channel: stage counts must be non-negative");
  end

  logic             accept;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;

  assign accept = inValid && inReady;

  // ---------------------------------------------------------------- forward line
  if (CYCLES == 0) begin : g_no_stages
    assign wr_en   = accept;
    assign wr_data = inData;
  end else begin : g_stages
    logic [CYCLES-1:0] stage_valid_q, stage_valid_d;
    logic [WIDTH-1:0]  stage_data_q [CYCLES];
    logic [WIDTH-1:0]  stage_data_d [CYCLES];

    always_comb begin
      stage_valid_d[0] = accept;
      stage_data_d[0]  = inData;
      for (int i = 1; i < CYCLES; i++) begin
        stage_valid_d[i] = stage_valid_q[i-1];
        stage_data_d[i]  = stage_data_q[i-1];
      end
    end

    // NOTE: sequential state is written only with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour, independent of process order.
    always_ff @(posedge clk) begin
      if (rst) stage_valid_q <= '0;
      else     stage_valid_q <= stage_valid_d;
    end

    // NOTE: payload stages carry no reset and no enable; only the valid bits need a known
    // value, and plain registers are what lets the retimer move them along the route.
    always_ff @(posedge clk) begin
      stage_data_q <= stage_data_d;
    end

    assign wr_en   = stage_valid_q[CYCLES-1];
    assign wr_data = stage_data_q[CYCLES-1];
  end

  // ---------------------------------------------------------------- FIFO + credit state
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occupancy_q, occupancy_d;
  logic [PW-1:0]    pipe_count_q, pipe_count_d;
  logic             overflow_q, overflow_d;
  logic             ready_raw_q, ready_raw_d;
  logic             full, empty, pop, push_ok;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    full     = (occupancy_q == OW'(FIFO_DEPTH));
    empty    = (occupancy_q == '0);
    pop      = outReady && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    push_ok  = wr_en && (!full || pop);

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occupancy_d  = occupancy_q;
    pipe_count_d = pipe_count_q;
    overflow_d   = overflow_q || (wr_en && full && !pop);

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

    if (push_ok && !pop)      occupancy_d = occupancy_q + 1'b1;
    else if (pop && !push_ok) occupancy_d = occupancy_q - 1'b1;

    if (accept && !wr_en)      pipe_count_d = pipe_count_q + 1'b1;
    else if (!accept && wr_en) pipe_count_d = pipe_count_q - 1'b1;

    // Headroom covers items that can still be accepted while the ready decision travels back.
    ready_raw_d = (int'(occupancy_q) + int'(pipe_count_q) + READY_CYCLES + 2) <= FIFO_DEPTH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occupancy_q  <= '0;
      pipe_count_q <= '0;
      overflow_q   <= 1'b0;
      ready_raw_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occupancy_q  <= occupancy_d;
      pipe_count_q <= pipe_count_d;
      overflow_q   <= overflow_d;
      ready_raw_q  <= ready_raw_d;
    end
  end

  // NOTE: storage is not reset; the pointers and occupancy alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  // ---------------------------------------------------------------- ready return line
  if (READY_CYCLES == 0) begin : g_no_ready_pipe
    assign inReady = ready_raw_q;
  end else begin : g_ready_pipe
    logic [READY_CYCLES-1:0] ready_pipe_q, ready_pipe_d;

    always_comb begin
      ready_pipe_d[0] = ready_raw_q;
      for (int i = 1; i < READY_CYCLES; i++) begin
        ready_pipe_d[i] = ready_pipe_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) ready_pipe_q <= '0;
      else     ready_pipe_q <= ready_pipe_d;
    end

    assign inReady = ready_pipe_q[READY_CYCLES-1];
  end

  assign outValid    = !empty;
  assign outData     = mem_q[rd_ptr_q];
  assign occupancy   = occupancy_q;
  assign overflowErr = overflow_q;

`ifdef HYPERPIPE_CHANNEL_STATS_EN
  // ---------------------------------------------------------------- statistics
  logic [OW-1:0] max_occ_q, max_occ_d;
  logic [31:0]   stall_q, stall_d;
  logic [31:0]   starve_q, starve_d;

  always_comb begin
    max_occ_d = max_occ_q;
    stall_d   = stall_q;
    starve_d  = starve_q;
    if (occupancy_q > max_occ_q)                    max_occ_d = occupancy_q;
    if (inValid && !inReady && stall_q != '1)       stall_d   = stall_q + 1'b1;
    if (outReady && !outValid && starve_q != '1)    starve_d  = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_occ_q <= '0;
      stall_q   <= '0;
      starve_q  <= '0;
    end else begin
      max_occ_q <= max_occ_d;
      stall_q   <= stall_d;
      starve_q  <= starve_d;
    end
  end

  assign maxOccupancy = max_occ_q;
  assign stallCycles  = stall_q;
  assign starveCycles = starve_q;
`endif

endmodule

// File: tb/tb_hyperpipe_credit_channel.sv
// Scoreboard bench for hyperpipe_credit_channel: directed tests on the default build plus
// randomized traffic on three extra stage configurations.
module tb_hyperpipe_credit_channel;

  localparam int OW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- main instance
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, overflow_err;
  logic [31:0]   in_data, out_data;
  logic [OW-1:0] occupancy;
`ifdef HYPERPIPE_CHANNEL_STATS_EN
  logic [OW-1:0] max_occ;
  logic [31:0]   stall_cnt, starve_cnt;
`endif

  hyperpipe_credit_channel #(.WIDTH(32), .CYCLES(4), .READY_CYCLES(2), .FIFO_DEPTH(32)) u_main (
    .clk         (clk),
    .rst         (rst),
    .inValid     (in_valid),
    .inData      (in_data),
    .inReady     (in_ready),
    .outValid    (out_valid),
    .outData     (out_data),
    .outReady    (out_ready),
    .occupancy   (occupancy),
    .overflowErr (overflow_err)
`ifdef HYPERPIPE_CHANNEL_STATS_EN
    ,
    .maxOccupancy(max_occ),
    .stallCycles (stall_cnt),
    .starveCycles(starve_cnt)
`endif
  );

  logic [31:0] main_q [$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (main_q.size() == 0) check("main_unexpected_item_valid", 32'(out_valid), 32'd0);
      else                    check("main_data", out_data, main_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic r, output logic acc);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    acc = v && in_ready && !rst;
    if (acc) main_q.push_back(d);
  endtask

  // ---------------------------------------------------------------- random instances
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int C = (g == 0) ? 0 : (g == 1) ? 1 : 7;
    localparam int R = (g == 0) ? 3 : (g == 1) ? 0 : 3;

    logic          r_rst, iv, ir, ov, orr, ovf;
    logic [31:0]   id, od, cnt;
    logic [OW-1:0] occ;
    logic          done = 1'b0;
    logic [31:0]   q [$];
`ifdef HYPERPIPE_CHANNEL_STATS_EN
    logic [OW-1:0] s_max;
    logic [31:0]   s_stall, s_starve;
`endif

    hyperpipe_credit_channel #(.WIDTH(32), .CYCLES(C), .READY_CYCLES(R), .FIFO_DEPTH(32)) u_dut (
      .clk         (clk),
      .rst         (r_rst),
      .inValid     (iv),
      .inData      (id),
      .inReady     (ir),
      .outValid    (ov),
      .outData     (od),
      .outReady    (orr),
      .occupancy   (occ),
      .overflowErr (ovf)
`ifdef HYPERPIPE_CHANNEL_STATS_EN
      ,
      .maxOccupancy(s_max),
      .stallCycles (s_stall),
      .starveCycles(s_starve)
`endif
    );

    always @(negedge clk) begin
      if (!r_rst && ov && orr) begin
        if (q.size() == 0) check($sformatf("rand%0d_unexpected_item_valid", g), 32'(ov), 32'd0);
        else               check($sformatf("rand%0d_data", g), od, q.pop_front());
      end
    end

    initial begin
      r_rst = 1'b1;
      iv    = 1'b0;
      id    = '0;
      orr   = 1'b0;
      cnt   = 32'h1000_0000 * (g + 1);
      repeat (3) @(posedge clk);
      #1 r_rst = 1'b0;
      for (int c = 0; c < 10000; c++) begin
        @(posedge clk);
        #1;
        iv  = 1'($urandom_range(0, 1));
        id  = cnt;
        orr = 1'($urandom_range(0, 1));
        if (iv && ir) begin
          q.push_back(cnt);
          cnt++;
        end
      end
      @(posedge clk);
      #1;
      iv  = 1'b0;
      orr = 1'b1;
      for (int c = 0; c < 300 && q.size() != 0; c++) @(posedge clk);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d_drained", g), 32'(q.size()), 32'd0);
      check($sformatf("rand%0d_occ_zero", g), 32'(occ), 32'd0);
      check($sformatf("rand%0d_no_overflow", g), 32'(ovf), 32'd0);
      done = 1'b1;
    end
  end

  // ---------------------------------------------------------------- directed sequence
  logic        acc;
  logic [31:0] cnt;
  int          max_seen;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state and first inReady three edges after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_overflow", 32'(overflow_err), 32'd0);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, acc);
    check("ready_edge1", 32'(in_ready), 32'd0);
    step(1'b0, '0, 1'b0, acc);
    check("ready_edge2", 32'(in_ready), 32'd0);
    step(1'b0, '0, 1'b0, acc);
    check("ready_edge3", 32'(in_ready), 32'd1);

    // Single item: outValid exactly one cycle, five edges after it is driven.
    step(1'b1, 32'hA5, 1'b1, acc);
    check("single_accepted", 32'(acc), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, '0, 1'b1, acc);
      check($sformatf("latency_valid_edge%0d", i), 32'(out_valid), (i == 5) ? 32'd1 : 32'd0);
    end
    check("single_occ_zero", 32'(occupancy), 32'd0);

    // Continuous push with downstream stalled: credits stop exactly at a full FIFO.
    cnt      = 0;
    max_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, cnt, 1'b0, acc);
      if (acc) cnt++;
      if (int'(occupancy) > max_seen) max_seen = int'(occupancy);
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, acc);
    check("fill_in_ready_low", 32'(in_ready), 32'd0);
    check("fill_occ_at_least_28", 32'(occupancy >= 28), 32'd1);
    check("fill_max_le_32", 32'(max_seen <= 32), 32'd1);
    check("fill_occ_full", 32'(occupancy), 32'd32);
    check("fill_no_overflow", 32'(overflow_err), 32'd0);

    // Forced push into the full FIFO bypasses the credit gate.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'hBAD0_BAD0;
    force u_main.accept = 1'b1;
    @(posedge clk);
    #1;
    release u_main.accept;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, acc);
    check("ovf_set", 32'(overflow_err), 32'd1);
    check("ovf_occ_unchanged", 32'(occupancy), 32'd32);

    // Drain: monitor checks items 0..31 in order, dropped item never appears.
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, acc);
    check("drain_queue_empty", 32'(main_q.size()), 32'd0);
    check("drain_occ_zero", 32'(occupancy), 32'd0);
    check("ovf_sticky", 32'(overflow_err), 32'd1);

    // Reset with ten items in flight.
    for (int i = 0; i < 10; i++) step(1'b1, 32'h200 + i, 1'b0, acc);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    main_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_occupancy", 32'(occupancy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_overflow_clear", 32'(overflow_err), 32'd0);
`ifdef HYPERPIPE_CHANNEL_STATS_EN
    check("midrst_max_occ", 32'(max_occ), 32'd0);
    check("midrst_stall", stall_cnt, 32'd0);
    check("midrst_starve", starve_cnt, 32'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 10 && !in_ready; i++) step(1'b0, '0, 1'b0, acc);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + i, 1'b1, acc);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, acc);
    check("post_rst_queue_empty", 32'(main_q.size()), 32'd0);
    check("post_rst_occ_zero", 32'(occupancy), 32'd0);

    // Wait for the randomized instances, bounded.
    for (int c = 0; c < 30000 && !(g_rand[0].done && g_rand[1].done && g_rand[2].done); c++)
      @(posedge clk);
    check("rand0_finished", 32'(g_rand[0].done), 32'd1);
    check("rand1_finished", 32'(g_rand[1].done), 32'd1);
    check("rand2_finished", 32'(g_rand[2].done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
